in_splitter: RTL and testbench
==============================

# in_splitter

Receive-side counterpart of the transmit merger: accepts one UDP meta/data stream from the UDP receive engine and steers each whole packet (meta plus all data beats) to exactly one of two consumers, the setup path or the prep path, by matching the UDP destination port. It sits between the UDP RX engine and the VR application blocks. Packets are never interleaved. Meta is registered once per packet, and data is passed through combinationally once the meta has been delivered.

## Interface
Parameters:
- NOC_DATA_W, -1 (must be overridden), data beat width in bits
- NOC_PADBYTES, NOC_DATA_W/8, bytes per beat
- NOC_PADBYTES_W, $clog2(NOC_PADBYTES), padbytes field width
- SETUP_PORT, 16'd0, dst_port value routed to the setup consumer
- PREP_PORT, 16'd0, dst_port value routed to the prep consumer

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_splitter_meta_val / splitter_src_meta_rdy  in/out  1  source meta handshake
- src_splitter_meta_info  in  UDP_INFO_W  udp_info from the RX engine
- src_splitter_data_val / splitter_src_data_rdy  in/out  1  source data handshake
- src_splitter_data  in  NOC_DATA_W  data beat
- src_splitter_data_padbytes  in  NOC_PADBYTES_W  invalid bytes in the beat
- src_splitter_data_last  in  1  final beat of the packet
- splitter_setup_meta_val / setup_splitter_meta_rdy, splitter_setup_meta_info: setup meta output (1/1/UDP_INFO_W)
- splitter_setup_data_val / setup_splitter_data_rdy, splitter_setup_data, _padbytes, _last: setup data output
- splitter_prep_* / prep_splitter_*: the same set of signals for the prep consumer
- dropped_cnt  out  16  count of dropped packets; this port exists only when IN_SPLITTER_DROP_EN is defined

## Operation
State machine states are IDLE, META_OUT, DATA_PASS and DROP.
- IDLE:
  - splitter_src_meta_rdy=1.
  - On a meta handshake: latch info into meta_reg and compute dest_reg.
  - dest_reg = SETUP when dst_port==SETUP_PORT; else PREP when dst_port==PREP_PORT; else UNMATCHED.
  - SETUP_PORT is checked first if both parameters are equal.
  - Next state: META_OUT, or DROP if dest_reg is UNMATCHED under the macro.
- META_OUT:
  - The selected consumer's meta_val=1 with info=meta_reg; the other consumer's meta_val=0.
  - On the selected consumer's meta_rdy: go to DATA_PASS.
- DATA_PASS:
  - The selected consumer's data_val = src data_val.
  - splitter_src_data_rdy = the selected consumer's data_rdy.
  - data, padbytes and last are driven to both consumers; only the selected consumer sees val.
  - On a handshake with last=1: go to IDLE.
- DROP:
  - splitter_src_data_rdy=1 and no consumer val is asserted.
  - On a source data handshake with last=1: dropped_cnt increments (wrapping at 16'hFFFF→0), then go to IDLE.
- Outside DATA_PASS/DROP, splitter_src_data_rdy=0. Source data that arrives early is held off.
- No output val depends combinationally on a consumer rdy, except data_rdy pass-through in DATA_PASS.

## Timing
- Reset:
  - state=IDLE, meta_reg=0, dest_reg=PREP, dropped_cnt=0.
  - All val outputs are 0 and splitter_src_data_rdy=0.
  - splitter_src_meta_rdy=1 in the first cycle after reset deasserts.
- Meta latency:
  - Meta is accepted in cycle N; the selected consumer's meta_val is high in cycle N+1.
  - meta_val is held stable until rdy.
- Data latency is zero: the beat appears combinationally in DATA_PASS.
- A single-beat packet (last on the first beat) occupies IDLE, META_OUT, DATA_PASS: a minimum of 3 cycles per packet.
- Back-to-back packets: the next meta is accepted in the cycle after the last beat's handshake.
- rst asserted mid-packet returns to IDLE immediately. The partial packet is abandoned, and the consumers must also be reset.
- Consumer meta_rdy may stay low indefinitely; the block stalls with no loss of data.

## Configuration
- Macro: IN_SPLITTER_DROP_EN.
- Defined:
  - UNMATCHED packets enter DROP: meta is never forwarded and all data is consumed until last.
  - The dropped_cnt port exists.
- Undefined:
  - UNMATCHED packets route to the prep consumer, the same as PREP.
  - There is no DROP state and no dropped_cnt port.

## Structure
- The shared package beehive_vr_pkg gains:
  - the split_dest_e enum (SETUP, PREP, UNMATCHED)
  - the split_state_e enum
- udp_info and UDP_INFO_W come from beehive_udp_msg.
- No sub-module is needed. The val/rdy steering reuses the existing demux_one_hot and bsg_mux_one_hot, driven from dest_reg decoded to one-hot.

## Test plan
- Setup routing: SETUP_PORT=16'd100; meta dst_port=100 with 3 beats (last on beat 3, padbytes=5 on beat 3).
  - All three beats appear only on setup, with padbytes 5 on beat 3.
  - Prep val stays 0 throughout.
- Prep routing: PREP_PORT=16'd200; two back-to-back 1-beat packets to port 200.
  - The second meta is accepted the cycle after the first last handshake.
  - Prep sees 2 meta and 2 data handshakes; minimum spacing is 3 cycles.
- Backpressure: the setup consumer holds meta_rdy=0 for 10 cycles, then toggles data_rdy every cycle.
  - meta_val and info stay stable.
  - splitter_src_data_rdy mirrors data_rdy; no beats are lost or duplicated.
- Unmatched port, dst_port=300, 4 beats:
  - With the macro: nothing is forwarded and dropped_cnt goes 0→1.
  - Without the macro: the packet appears on prep.
- Mid-packet reset: rst for 1 cycle after beat 2 of 5.
  - All vals go to 0 and state returns to IDLE.
  - The next packet (port 100) routes cleanly to setup.
- Early data: source data_val=1 before meta.
  - splitter_src_data_rdy stays 0 until DATA_PASS.

Source files
------------

// File: rtl/in_splitter_pkg.sv
// Shared types for the in_splitter RX packet steering block: UDP info layout and split enums.
package in_splitter_pkg;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] data_length;
  } udp_info;

  localparam int UDP_INFO_W = $bits(udp_info);

  typedef enum logic [1:0] {SETUP = 2'd0, PREP = 2'd1, UNMATCHED = 2'd2} split_dest_e;

  typedef enum logic [1:0] {IDLE = 2'd0, META_OUT = 2'd1, DATA_PASS = 2'd2, DROP = 2'd3} split_state_e;

  // Setup port wins when both configured ports are equal.
  function automatic split_dest_e split_dest(input logic [15:0] dst_port,
                                             input logic [15:0] setup_port,
                                             input logic [15:0] prep_port);
    if (dst_port == setup_port) return SETUP;
    else if (dst_port == prep_port) return PREP;
    else return UNMATCHED;
  endfunction

endpackage

// File: rtl/in_splitter.sv
// Steers whole UDP packets to setup or prep by dst_port; meta is 1-cycle registered, data is 0-latency
// pass-through under consumer rdy. IN_SPLITTER_DROP_EN drops unmatched packets and adds dropped_cnt.
module in_splitter
  import in_splitter_pkg::*;
#(
  parameter int          NOC_DATA_W     = -1,
  parameter int          NOC_PADBYTES   = NOC_DATA_W / 8,
  parameter int          NOC_PADBYTES_W = $clog2(NOC_PADBYTES),
  parameter logic [15:0] SETUP_PORT     = 16'd0,
  parameter logic [15:0] PREP_PORT      = 16'd0
) (
  input  logic                      clk,
  input  logic                      rst,

  input  logic                      src_splitter_meta_val,
  output logic                      splitter_src_meta_rdy,
  input  logic [UDP_INFO_W-1:0]     src_splitter_meta_info,
  input  logic                      src_splitter_data_val,
  output logic                      splitter_src_data_rdy,
  input  logic [NOC_DATA_W-1:0]     src_splitter_data,
  input  logic [NOC_PADBYTES_W-1:0] src_splitter_data_padbytes,
  input  logic                      src_splitter_data_last,

  output logic                      splitter_setup_meta_val,
  input  logic                      setup_splitter_meta_rdy,
  output logic [UDP_INFO_W-1:0]     splitter_setup_meta_info,
  output logic                      splitter_setup_data_val,
  input  logic                      setup_splitter_data_rdy,
  output logic [NOC_DATA_W-1:0]     splitter_setup_data,
  output logic [NOC_PADBYTES_W-1:0] splitter_setup_data_padbytes,
  output logic                      splitter_setup_data_last,

  output logic                      splitter_prep_meta_val,
  input  logic                      prep_splitter_meta_rdy,
  output logic [UDP_INFO_W-1:0]     splitter_prep_meta_info,
  output logic                      splitter_prep_data_val,
  input  logic                      prep_splitter_data_rdy,
  output logic [NOC_DATA_W-1:0]     splitter_prep_data,
  output logic [NOC_PADBYTES_W-1:0] splitter_prep_data_padbytes,
  output logic                      splitter_prep_data_last
`ifdef IN_SPLITTER_DROP_EN
  ,
  output logic [15:0]               dropped_cnt
`endif
);

  split_state_e          state, state_nxt;
  split_dest_e           dest_reg, dest_in;
  logic [UDP_INFO_W-1:0] meta_reg;
  udp_info               src_info;
  logic [1:0]            sel_oh;
  logic                  meta_hs, data_hs, sel_meta_rdy, sel_data_rdy;

  assign src_info = udp_info'(src_splitter_meta_info);
  assign dest_in  = split_dest(src_info.dst_port, SETUP_PORT, PREP_PORT);

  // One-hot consumer select: bit 0 setup, bit 1 prep (unmatched falls to prep when not dropping).
  assign sel_oh       = (dest_reg == SETUP) ? 2'b01 : 2'b10;
  assign sel_meta_rdy = sel_oh[0] ? setup_splitter_meta_rdy : prep_splitter_meta_rdy;
  assign sel_data_rdy = sel_oh[0] ? setup_splitter_data_rdy : prep_splitter_data_rdy;
  assign meta_hs      = src_splitter_meta_val & splitter_src_meta_rdy;
  assign data_hs      = src_splitter_data_val & splitter_src_data_rdy;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= '0;
      dest_reg <= PREP;
    end else if (meta_hs) begin
      meta_reg <= src_splitter_meta_info;
      dest_reg <= dest_in;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (meta_hs) begin
`ifdef IN_SPLITTER_DROP_EN
          state_nxt = (dest_in == UNMATCHED) ? DROP : META_OUT;
`else
          state_nxt = META_OUT;
`endif
        end
      end
      META_OUT:  if (sel_meta_rdy) state_nxt = DATA_PASS;
      DATA_PASS: if (data_hs && src_splitter_data_last) state_nxt = IDLE;
`ifdef IN_SPLITTER_DROP_EN
      DROP:      if (data_hs && src_splitter_data_last) state_nxt = IDLE;
`endif
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    splitter_src_meta_rdy   = 1'b0;
    splitter_src_data_rdy   = 1'b0;
    splitter_setup_meta_val = 1'b0;
    splitter_prep_meta_val  = 1'b0;
    splitter_setup_data_val = 1'b0;
    splitter_prep_data_val  = 1'b0;
    case (state)
      IDLE:     splitter_src_meta_rdy = 1'b1;
      META_OUT: begin
        splitter_setup_meta_val = sel_oh[0];
        splitter_prep_meta_val  = sel_oh[1];
      end
      DATA_PASS: begin
        splitter_setup_data_val = sel_oh[0] & src_splitter_data_val;
        splitter_prep_data_val  = sel_oh[1] & src_splitter_data_val;
        splitter_src_data_rdy   = sel_data_rdy;
      end
`ifdef IN_SPLITTER_DROP_EN
      DROP:     splitter_src_data_rdy = 1'b1;
`endif
      default: ;
    endcase
  end

  assign splitter_setup_meta_info     = meta_reg;
  assign splitter_prep_meta_info      = meta_reg;
  assign splitter_setup_data          = src_splitter_data;
  assign splitter_prep_data           = src_splitter_data;
  assign splitter_setup_data_padbytes = src_splitter_data_padbytes;
  assign splitter_prep_data_padbytes  = src_splitter_data_padbytes;
  assign splitter_setup_data_last     = src_splitter_data_last;
  assign splitter_prep_data_last      = src_splitter_data_last;

`ifdef IN_SPLITTER_DROP_EN
  always_ff @(posedge clk) begin
    if (rst) dropped_cnt <= 16'd0;
    else if (state == DROP && data_hs && src_splitter_data_last) dropped_cnt <= dropped_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_in_splitter.sv
// Scoreboard bench for in_splitter: routing, back-to-back, backpressure, unmatched, mid-packet reset, early data.
module tb_in_splitter;
  localparam int DW = 64;
  localparam int PW = 3;
  localparam int IW = 112;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [PW-1:0] p;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic src_meta_val = 0, src_data_val = 0, src_last = 0;
  logic [IW-1:0] src_info = '0;
  logic [DW-1:0] src_data = '0;
  logic [PW-1:0] src_pad = '0;
  logic src_meta_rdy, src_data_rdy;
  logic su_meta_val, su_meta_rdy = 1, su_data_val, su_data_rdy = 1, su_last;
  logic pr_meta_val, pr_meta_rdy = 1, pr_data_val, pr_data_rdy = 1, pr_last;
  logic [IW-1:0] su_info, pr_info;
  logic [DW-1:0] su_data, pr_data;
  logic [PW-1:0] su_pad, pr_pad;
`ifdef IN_SPLITTER_DROP_EN
  logic [15:0] dropped_cnt;
`endif

  in_splitter #(.NOC_DATA_W(DW), .NOC_PADBYTES(8), .NOC_PADBYTES_W(PW),
                .SETUP_PORT(16'd100), .PREP_PORT(16'd200)) dut (
    .clk(clk), .rst(rst),
    .src_splitter_meta_val(src_meta_val), .splitter_src_meta_rdy(src_meta_rdy),
    .src_splitter_meta_info(src_info),
    .src_splitter_data_val(src_data_val), .splitter_src_data_rdy(src_data_rdy),
    .src_splitter_data(src_data), .src_splitter_data_padbytes(src_pad),
    .src_splitter_data_last(src_last),
    .splitter_setup_meta_val(su_meta_val), .setup_splitter_meta_rdy(su_meta_rdy),
    .splitter_setup_meta_info(su_info),
    .splitter_setup_data_val(su_data_val), .setup_splitter_data_rdy(su_data_rdy),
    .splitter_setup_data(su_data), .splitter_setup_data_padbytes(su_pad),
    .splitter_setup_data_last(su_last),
    .splitter_prep_meta_val(pr_meta_val), .prep_splitter_meta_rdy(pr_meta_rdy),
    .splitter_prep_meta_info(pr_info),
    .splitter_prep_data_val(pr_data_val), .prep_splitter_data_rdy(pr_data_rdy),
    .splitter_prep_data(pr_data), .splitter_prep_data_padbytes(pr_pad),
    .splitter_prep_data_last(pr_last)
`ifdef IN_SPLITTER_DROP_EN
    , .dropped_cnt(dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0, errs = 0, cyc = 0;
  int prep_val_cnt = 0, prep_dhs = 0;
  int src_meta_cyc[$], src_last_cyc[$], prep_meta_cyc[$];
  logic [IW-1:0] su_mq[$], pr_mq[$];
  beat_t su_dq[$], pr_dq[$];
  logic [IW-1:0] cur_info;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every consumer handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (su_meta_val && su_meta_rdy) begin
        vectors++;
        if (su_mq.size() == 0) begin
          errs++; $display("FAIL setup_meta_unexpected info=%h", su_info);
        end else begin
          logic [IW-1:0] e;
          e = su_mq.pop_front();
          if (su_info !== e) begin errs++; $display("FAIL setup_meta got=%h exp=%h", su_info, e); end
        end
      end
      if (su_data_val && su_data_rdy) begin
        vectors++;
        if (su_dq.size() == 0) begin
          errs++; $display("FAIL setup_data_unexpected data=%h", su_data);
        end else begin
          beat_t e;
          e = su_dq.pop_front();
          if ({su_data, su_pad, su_last} !== e) begin
            errs++; $display("FAIL setup_data got=%h/%0d/%b exp=%h/%0d/%b", su_data, su_pad, su_last, e.d, e.p, e.l);
          end
        end
      end
      if (pr_meta_val && pr_meta_rdy) begin
        vectors++;
        prep_meta_cyc.push_back(cyc);
        if (pr_mq.size() == 0) begin
          errs++; $display("FAIL prep_meta_unexpected info=%h", pr_info);
        end else begin
          logic [IW-1:0] e;
          e = pr_mq.pop_front();
          if (pr_info !== e) begin errs++; $display("FAIL prep_meta got=%h exp=%h", pr_info, e); end
        end
      end
      if (pr_data_val && pr_data_rdy) begin
        vectors++;
        prep_dhs++;
        if (pr_dq.size() == 0) begin
          errs++; $display("FAIL prep_data_unexpected data=%h", pr_data);
        end else begin
          beat_t e;
          e = pr_dq.pop_front();
          if ({pr_data, pr_pad, pr_last} !== e) begin
            errs++; $display("FAIL prep_data got=%h/%0d/%b exp=%h/%0d/%b", pr_data, pr_pad, pr_last, e.d, e.p, e.l);
          end
        end
      end
      if (pr_meta_val || pr_data_val) prep_val_cnt++;
      if (src_meta_val && src_meta_rdy) src_meta_cyc.push_back(cyc);
      if (src_data_val && src_data_rdy && src_last) src_last_cyc.push_back(cyc);
    end
  end

  // Waits for a source handshake (0=meta, 1=data); returns at posedge+#1 after it.
  task automatic wait_src_hs(input int which);
    logic ok;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ok = (which == 0) ? src_meta_rdy : src_data_rdy;
      @(posedge clk); #1;
      if (ok) return;
    end
    vectors++; errs++;
    $display("FAIL src_handshake_timeout which=%0d got=no_rdy exp=rdy", which);
  endtask

  // route: 0 setup, 1 prep, 2 not forwarded
  task automatic send_pkt(input logic [15:0] port, input int nbeats, input logic [PW-1:0] last_pad, input int route);
    beat_t b;
    cur_info = {32'hC0A80001, 32'hC0A80002, 16'($urandom_range(1024, 65535)), port, 16'd64};
    if (route == 0) su_mq.push_back(cur_info);
    else if (route == 1) pr_mq.push_back(cur_info);
    src_info = cur_info;
    src_meta_val = 1;
    wait_src_hs(0);
    src_meta_val = 0;
    for (int i = 0; i < nbeats; i++) begin
      b.d = {$urandom, $urandom};
      b.l = (i == nbeats - 1);
      b.p = b.l ? last_pad : '0;
      if (route == 0) su_dq.push_back(b);
      else if (route == 1) pr_dq.push_back(b);
      {src_data, src_pad, src_last} = b;
      src_data_val = 1;
      wait_src_hs(1);
    end
    src_data_val = 0;
    src_last = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    vectors++;
    if ({su_meta_val, su_data_val, pr_meta_val, pr_data_val, src_data_rdy} !== 5'b0) begin
      errs++; $display("FAIL reset_vals got=%b exp=00000", {su_meta_val, su_data_val, pr_meta_val, pr_data_val, src_data_rdy});
    end
    vectors++;
    if (src_meta_rdy !== 1'b1) begin errs++; $display("FAIL reset_meta_rdy got=%b exp=1", src_meta_rdy); end
`ifdef IN_SPLITTER_DROP_EN
    vectors++;
    if (dropped_cnt !== 16'd0) begin errs++; $display("FAIL reset_dropped_cnt got=%0d exp=0", dropped_cnt); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_setup_routing();
    int p0;
    p0 = prep_val_cnt;
    send_pkt(16'd100, 3, 3'd5, 0);
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (prep_val_cnt !== p0) begin errs++; $display("FAIL setup_route_prep_val got=%0d exp=%0d", prep_val_cnt, p0); end
  endtask

  task automatic test_back_to_back();
    int dh0;
    src_meta_cyc.delete(); src_last_cyc.delete(); prep_meta_cyc.delete();
    dh0 = prep_dhs;
    send_pkt(16'd200, 1, 3'd1, 1);
    send_pkt(16'd200, 1, 3'd2, 1);
    repeat (3) @(posedge clk); #1;
    vectors++;
    if (prep_meta_cyc.size() != 2 || prep_dhs - dh0 != 2) begin
      errs++; $display("FAIL b2b_counts got=%0d/%0d exp=2/2", prep_meta_cyc.size(), prep_dhs - dh0);
    end else begin
      vectors++;
      if (prep_meta_cyc[1] - prep_meta_cyc[0] != 3) begin
        errs++; $display("FAIL b2b_spacing got=%0d exp=3", prep_meta_cyc[1] - prep_meta_cyc[0]);
      end
    end
    vectors++;
    if (src_meta_cyc.size() < 2 || src_last_cyc.size() < 1) begin
      errs++; $display("FAIL b2b_src_hs got=%0d/%0d exp=2/1", src_meta_cyc.size(), src_last_cyc.size());
    end else if (src_meta_cyc[1] != src_last_cyc[0] + 1) begin
      errs++; $display("FAIL b2b_meta_accept got=%0d exp=%0d", src_meta_cyc[1], src_last_cyc[0] + 1);
    end
  endtask

  task automatic test_backpressure();
    logic done;
    done = 0;
    su_meta_rdy = 0;
    fork
      begin
        send_pkt(16'd100, 4, 3'd2, 0);
        done = 1;
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!su_meta_val && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
          vectors++;
          if (su_meta_val !== 1'b1 || su_info !== cur_info) begin
            errs++; $display("FAIL bp_meta_hold got=%b/%h exp=1/%h", su_meta_val, su_info, cur_info);
          end
          @(negedge clk);
        end
        @(posedge clk); #1 su_meta_rdy = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 100 && !done; i++) begin
          @(negedge clk);
          if (!done) begin
            vectors++;
            if (src_data_rdy !== su_data_rdy) begin
              errs++; $display("FAIL bp_rdy_mirror got=%b exp=%b", src_data_rdy, su_data_rdy);
            end
          end
          @(posedge clk); #1;
          if (!done) su_data_rdy = ~su_data_rdy;
        end
      end
    join
    su_data_rdy = 1;
    su_meta_rdy = 1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_unmatched();
    int p0;
    p0 = prep_val_cnt;
`ifdef IN_SPLITTER_DROP_EN
    vectors++;
    if (dropped_cnt !== 16'd0) begin errs++; $display("FAIL drop_cnt_before got=%0d exp=0", dropped_cnt); end
    send_pkt(16'd300, 4, 3'd1, 2);
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (dropped_cnt !== 16'd1) begin errs++; $display("FAIL drop_cnt_after got=%0d exp=1", dropped_cnt); end
    vectors++;
    if (prep_val_cnt !== p0) begin errs++; $display("FAIL drop_forwarded got=%0d exp=%0d", prep_val_cnt, p0); end
`else
    send_pkt(16'd300, 4, 3'd1, 1);
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (prep_val_cnt - p0 < 5) begin errs++; $display("FAIL unmatched_to_prep got=%0d exp>=5", prep_val_cnt - p0); end
`endif
  endtask

  task automatic test_mid_reset();
    beat_t b;
    cur_info = {32'hC0A80001, 32'hC0A80002, 16'd7777, 16'd100, 16'd64};
    su_mq.push_back(cur_info);
    src_info = cur_info;
    src_meta_val = 1;
    wait_src_hs(0);
    src_meta_val = 0;
    for (int i = 0; i < 2; i++) begin
      b.d = {$urandom, $urandom}; b.p = '0; b.l = 0;
      su_dq.push_back(b);
      {src_data, src_pad, src_last} = b;
      src_data_val = 1;
      wait_src_hs(1);
    end
    src_data_val = 0;
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    vectors++;
    if ({su_meta_val, su_data_val, pr_meta_val, pr_data_val, src_data_rdy, src_meta_rdy} !== 6'b000001) begin
      errs++; $display("FAIL midrst_state got=%b exp=000001", {su_meta_val, su_data_val, pr_meta_val, pr_data_val, src_data_rdy, src_meta_rdy});
    end
    @(posedge clk); #1;
    send_pkt(16'd100, 2, 3'd3, 0);
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_early_data();
    beat_t b;
    b.d = {$urandom, $urandom}; b.p = 3'd4; b.l = 1;
    {src_data, src_pad, src_last} = b;
    src_data_val = 1;
    su_meta_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (src_data_rdy !== 1'b0) begin errs++; $display("FAIL early_rdy_idle got=%b exp=0", src_data_rdy); end
    end
    @(posedge clk); #1;
    cur_info = {32'hC0A80001, 32'hC0A80002, 16'd4242, 16'd100, 16'd64};
    su_mq.push_back(cur_info);
    su_dq.push_back(b);
    src_info = cur_info;
    src_meta_val = 1;
    wait_src_hs(0);
    src_meta_val = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (src_data_rdy !== 1'b0) begin errs++; $display("FAIL early_rdy_meta got=%b exp=0", src_data_rdy); end
      @(posedge clk); #1;
    end
    su_meta_rdy = 1;
    wait_src_hs(1);
    src_data_val = 0;
    src_last = 0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_drain();
    repeat (4) @(posedge clk); #1;
    vectors++;
    if (su_mq.size() + su_dq.size() + pr_mq.size() + pr_dq.size() != 0) begin
      errs++; $display("FAIL scoreboard_drain got=%0d/%0d/%0d/%0d exp=0/0/0/0", su_mq.size(), su_dq.size(), pr_mq.size(), pr_dq.size());
    end
  endtask

  initial begin
    test_reset();
    test_setup_routing();
    test_back_to_back();
    test_backpressure();
    test_unmatched();
    test_mid_reset();
    test_early_data();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
